router_sync_n: RTL and testbench

- Parametrised successor of the 1x3 router synchroniser; sits between the router FSM/register stage and NUM_CH output FIFOs.
- Latches the packet destination address and decodes the per-channel write enable.
- Muxes the full flag of the selected FIFO, drives the per-channel valid-out flags, and generates per-channel soft-reset pulses when a valid FIFO goes unread for a run-time-programmable number of cycles.
- Adds invalid-address detection and timeout disable, which the 3-channel version lacks.

---
 rtl/router_pkg.sv | 11 +
 rtl/router_sync_timer.sv | 39 +++
 rtl/router_sync_n.sv | 71 +++++++
 tb/tb_router_sync_n.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared defaults for the parametrised router synchroniser and its per-channel timers.
package router_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int ADDR_W_DEF = 2;
    localparam int CNT_W_DEF  = 5;

    // Stall length, in cycles, that the surrounding router normally programs.
    localparam int DEFAULT_TIMEOUT = 30;

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: pulses soft_reset for one cycle after timeout_cfg
// consecutive cycles in which the FIFO holds data that nobody reads.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             vld,
    input  logic             rd,
    input  logic [CNT_W-1:0] timeout_cfg,
    output logic             soft_reset
);

    logic [CNT_W-1:0] timer;
    logic             stall;

    assign stall = vld && !rd && (timeout_cfg != '0);

    // The >= compare lets a shrinking timeout_cfg fire on the next stalled edge
    // instead of waiting for the counter to wrap.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timer      <= '0;
            soft_reset <= 1'b0;
        end else if (!stall) begin
            timer      <= '0;
            soft_reset <= 1'b0;
        end else if (timer >= timeout_cfg - CNT_W'(1)) begin
            timer      <= '0;
            soft_reset <= 1'b1;
        end else begin
            timer      <= timer + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// NUM_CH-way router synchroniser: latches the destination address, steers the
// write enable and full flag, and owns one stall timer per output FIFO.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [CNT_W-1:0]  timeout_cfg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic              fifo_full,
    output logic              addr_err,
    output logic [NUM_CH-1:0] write_enb,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset
);

    // One extra bit so NUM_CH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_CH_EXT = NUM_CH[ADDR_W:0];

    logic [ADDR_W-1:0] fifo_addr;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            fifo_addr <= '0;
        end else if (detect_add) begin
            fifo_addr <= data_in;
        end
    end

    // An out-of-range address matches no channel, so write_enb and fifo_full
    // fall to zero on their own; addr_err is still gated explicitly below.
    always_comb begin
        addr_err  = 1'b0;
        fifo_full = 1'b0;
        write_enb = '0;
        if (resetn) begin
            addr_err = ({1'b0, fifo_addr} >= NUM_CH_EXT);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!addr_err && (fifo_addr == i[ADDR_W-1:0])) begin
                    fifo_full    = full[i];
                    write_enb[i] = write_enb_reg;
                end
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .CNT_W(CNT_W)
        ) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .timeout_cfg(timeout_cfg),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n with the default three channels.
module tb_router_sync_n;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [4:0] timeout_cfg;
    logic [2:0] read_enb;
    logic [2:0] empty;
    logic [2:0] full;
    logic       fifo_full;
    logic       addr_err;
    logic [2:0] write_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    router_sync_n dut (
        .clock        (clock),
        .resetn       (resetn),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .timeout_cfg  (timeout_cfg),
        .read_enb     (read_enb),
        .empty        (empty),
        .full         (full),
        .fifo_full    (fifo_full),
        .addr_err     (addr_err),
        .write_enb    (write_enb),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b1;
        timeout_cfg = 5'(DEFAULT_TIMEOUT); read_enb = 3'b000; empty = 3'b010; full = 3'b111;
        tick(); tick();
        chk_cnt++;
        if (write_enb !== 3'b000) $display("FAIL reset_write_enb: got %b expected 000", write_enb);
        else pass_cnt++;
        chk_cnt++;
        if (addr_err !== 1'b0 || fifo_full !== 1'b0)
            $display("FAIL reset_flags: got addr_err=%b fifo_full=%b expected 0 0", addr_err, fifo_full);
        else pass_cnt++;
        chk_cnt++;
        if (soft_reset !== 3'b000) $display("FAIL reset_soft_reset: got %b expected 000", soft_reset);
        else pass_cnt++;
        chk_cnt++;
        if (vld_out !== 3'b101) $display("FAIL reset_vld_out: got %b expected 101", vld_out);
        else pass_cnt++;
        resetn = 1'b1; detect_add = 1'b0; write_enb_reg = 1'b0; empty = 3'b111; full = 3'b000;
        tick();
    endtask

    task automatic test_addr_decode();
        detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b0;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
        #1;
        chk_cnt++;
        if (write_enb !== 3'b100 || addr_err !== 1'b0)
            $display("FAIL decode_addr2: got write_enb=%b addr_err=%b expected 100 0", write_enb, addr_err);
        else pass_cnt++;
        chk_cnt++;
        if (fifo_full !== 1'b1) $display("FAIL decode_full_sel: got %b expected 1", fifo_full);
        else pass_cnt++;
        full = 3'b011;
        #1;
        chk_cnt++;
        if (fifo_full !== 1'b0) $display("FAIL decode_full_other: got %b expected 0", fifo_full);
        else pass_cnt++;
        write_enb_reg = 1'b0;
        #1;
        chk_cnt++;
        if (write_enb !== 3'b000) $display("FAIL decode_no_req: got %b expected 000", write_enb);
        else pass_cnt++;
        // New address arrives in the same cycle as a write: old address still steers it.
        detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b1;
        #1;
        chk_cnt++;
        if (write_enb !== 3'b100) $display("FAIL decode_same_cycle: got %b expected 100", write_enb);
        else pass_cnt++;
        tick();
        detect_add = 1'b0;
        #1;
        chk_cnt++;
        if (write_enb !== 3'b010 || fifo_full !== 1'b1)
            $display("FAIL decode_addr1: got write_enb=%b fifo_full=%b expected 010 1", write_enb, fifo_full);
        else pass_cnt++;
        write_enb_reg = 1'b0; full = 3'b000;
    endtask

    task automatic test_addr_err();
        detect_add = 1'b1; data_in = 2'd3;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
        #1;
        chk_cnt++;
        if (addr_err !== 1'b1) $display("FAIL err_flag: got %b expected 1", addr_err);
        else pass_cnt++;
        chk_cnt++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0)
            $display("FAIL err_outputs: got write_enb=%b fifo_full=%b expected 000 0", write_enb, fifo_full);
        else pass_cnt++;
        detect_add = 1'b1; data_in = 2'd0; full = 3'b001;
        tick();
        detect_add = 1'b0;
        #1;
        chk_cnt++;
        if (addr_err !== 1'b0 || write_enb !== 3'b001 || fifo_full !== 1'b1)
            $display("FAIL err_recover: got addr_err=%b write_enb=%b fifo_full=%b expected 0 001 1",
                     addr_err, write_enb, fifo_full);
        else pass_cnt++;
        write_enb_reg = 1'b0; full = 3'b000;
    endtask

    task automatic test_stall_timeout();
        logic [2:0] exp;
        timeout_cfg = 5'(DEFAULT_TIMEOUT); read_enb = 3'b000; empty = 3'b111;
        tick();
        empty = 3'b110;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = (k == 30 || k == 60) ? 3'b001 : 3'b000;
            chk_cnt++;
            if (soft_reset !== exp)
                $display("FAIL stall_cycle%0d: got soft_reset=%b expected %b", k + 1, soft_reset, exp);
            else pass_cnt++;
        end
        empty = 3'b111;
        tick();
    endtask

    task automatic test_read_restart();
        logic [2:0] exp;
        empty = 3'b110;
        for (int k = 1; k <= 55; k++) begin
            read_enb = (k == 20) ? 3'b001 : 3'b000;
            tick();
            exp = (k == 50) ? 3'b001 : 3'b000;
            chk_cnt++;
            if (soft_reset !== exp)
                $display("FAIL read_restart_cycle%0d: got soft_reset=%b expected %b", k + 1, soft_reset, exp);
            else pass_cnt++;
        end
        read_enb = 3'b000; empty = 3'b111;
        tick();
    endtask

    task automatic test_empty_restart();
        for (int k = 1; k <= 60; k++) begin
            empty = (k >= 25) ? 3'b111 : 3'b110;
            tick();
            chk_cnt++;
            if (soft_reset !== 3'b000)
                $display("FAIL empty_restart_cycle%0d: got soft_reset=%b expected 000", k + 1, soft_reset);
            else pass_cnt++;
        end
        chk_cnt++;
        if (vld_out !== 3'b000) $display("FAIL empty_vld_out: got %b expected 000", vld_out);
        else pass_cnt++;
    endtask

    task automatic test_disable_and_shrink();
        int bad;
        timeout_cfg = 5'd0; empty = 3'b110;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (soft_reset !== 3'b000) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL disable_no_pulse: got %0d pulsing cycles expected 0", bad);
        else pass_cnt++;
        // Stall 10 cycles at cfg=30 to reach timer=10, then shrink to 4.
        empty = 3'b111; timeout_cfg = 5'(DEFAULT_TIMEOUT);
        tick();
        empty = 3'b110;
        for (int k = 1; k <= 10; k++) tick();
        chk_cnt++;
        if (soft_reset !== 3'b000) $display("FAIL shrink_before: got %b expected 000", soft_reset);
        else pass_cnt++;
        timeout_cfg = 5'd4;
        tick();
        chk_cnt++;
        if (soft_reset !== 3'b001) $display("FAIL shrink_fire: got %b expected 001", soft_reset);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_cnt++;
            if (soft_reset !== ((k == 4) ? 3'b001 : 3'b000))
                $display("FAIL shrink_period%0d: got %b expected %b", k, soft_reset,
                         (k == 4) ? 3'b001 : 3'b000);
            else pass_cnt++;
        end
        empty = 3'b111;
        tick();
    endtask

    task automatic test_cfg_one();
        timeout_cfg = 5'd1; empty = 3'b110;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_cnt++;
            if (soft_reset !== 3'b001) $display("FAIL cfg1_cycle%0d: got %b expected 001", k + 1, soft_reset);
            else pass_cnt++;
        end
        empty = 3'b111;
        tick();
        chk_cnt++;
        if (soft_reset !== 3'b000) $display("FAIL cfg1_stop: got %b expected 000", soft_reset);
        else pass_cnt++;
    endtask

    task automatic test_multi_channel();
        timeout_cfg = 5'd3; empty = 3'b000; read_enb = 3'b010;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_cnt++;
            if (soft_reset !== ((k == 3) ? 3'b101 : 3'b000))
                $display("FAIL multi_cycle%0d: got %b expected %b", k + 1, soft_reset,
                         (k == 3) ? 3'b101 : 3'b000);
            else pass_cnt++;
        end
        empty = 3'b111; read_enb = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        detect_add = 1'b1; data_in = 2'd2;
        tick();
        detect_add = 1'b0;
        timeout_cfg = 5'(DEFAULT_TIMEOUT); empty = 3'b110; read_enb = 3'b000;
        for (int k = 1; k <= 28; k++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; write_enb_reg = 1'b1;
        #1;
        chk_cnt++;
        if (soft_reset !== 3'b000 || write_enb !== 3'b001)
            $display("FAIL rstmid_after: got soft_reset=%b write_enb=%b expected 000 001", soft_reset, write_enb);
        else pass_cnt++;
        write_enb_reg = 1'b0;
        for (int k = 30; k <= 60; k++) begin
            tick();
            exp = (k == 59) ? 3'b001 : 3'b000;
            chk_cnt++;
            if (soft_reset !== exp)
                $display("FAIL rstmid_cycle%0d: got soft_reset=%b expected %b", k + 1, soft_reset, exp);
            else pass_cnt++;
        end
        empty = 3'b111;
        tick();
    endtask

    initial begin
        test_reset();
        test_addr_decode();
        test_addr_err();
        test_stall_timeout();
        test_read_restart();
        test_empty_restart();
        test_disable_and_shrink();
        test_cfg_one();
        test_multi_channel();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
